// File: rtl/param_proc_if.sv
// Instruction-fetch channel between param_proc (master) and an instruction memory (slave).
// The master holds imem_req/imem_addr steady until the slave answers with imem_valid.
interface param_proc_if #(
    parameter int PC_W = 7
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/param_proc.sv
// Purpose: tiny 8-register accumulator-free processor with fetch/execute FSM and Z/N/C/V flags.
// Latency: 2 cycles per instruction minimum (FETCH + EXEC); result_valid pulses the cycle after EXEC.
// Backpressure: FETCH stalls indefinitely with imem_req/imem_addr held until imem_valid=1.
module param_proc #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    param_proc_if.master      imem,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam int MSB = DATA_W - 1;

    state_t            state, state_nxt;
    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [8];

    logic [3:0]        opc;
    logic [2:0]        rd, rs1, rs2;
    logic [8:0]        imm9;
    logic [PC_W-1:0]   target;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W:0]   sum, diff;

    logic [DATA_W-1:0] alu;
    logic              rf_we, flag_we, c_new, v_new, br_take, halt_op;
    logic [PC_W-1:0]   pc_nxt;

    assign opc    = ir[15:12];
    assign rd     = ir[11:9];
    assign rs1    = ir[8:6];
    assign rs2    = ir[5:3];
    assign imm9   = ir[8:0];
    assign target = ir[PC_W-1:0];

    // Operands come from the pre-write register state, so rd==rs1/rs2 is naturally safe.
    assign op_a = rf[rs1];
    assign op_b = rf[rs2];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        case (ir[11:10])
            2'b00:   br_take = 1'b1;
            2'b01:   br_take = zero;
            2'b10:   br_take = negative;
            default: br_take = carry;
        endcase
    end

    always_comb begin
        alu     = '0;
        rf_we   = 1'b0;
        flag_we = 1'b0;
        c_new   = 1'b0;
        v_new   = 1'b0;
        halt_op = 1'b0;
        pc_nxt  = pc + PC_W'(1);
        case (opc)
            4'h1: begin
                alu     = sum[MSB:0];
                c_new   = sum[DATA_W];
                v_new   = (op_a[MSB] == op_b[MSB]) && (alu[MSB] != op_a[MSB]);
                rf_we   = 1'b1;
                flag_we = 1'b1;
            end
            4'h2, 4'h9: begin
                alu     = diff[MSB:0];
                c_new   = ~diff[DATA_W];
                v_new   = (op_a[MSB] != op_b[MSB]) && (alu[MSB] != op_a[MSB]);
                rf_we   = (opc == 4'h2);
                flag_we = 1'b1;
            end
            4'h3: begin alu = op_a & op_b; rf_we = 1'b1; flag_we = 1'b1; end
            4'h4: begin alu = op_a | op_b; rf_we = 1'b1; flag_we = 1'b1; end
            4'h5: begin alu = op_a ^ op_b; rf_we = 1'b1; flag_we = 1'b1; end
            4'h6: begin
                alu     = {op_a[MSB-1:0], 1'b0};
                c_new   = op_a[MSB];
                rf_we   = 1'b1;
                flag_we = 1'b1;
            end
            4'h7: begin
                alu     = {1'b0, op_a[MSB:1]};
                c_new   = op_a[0];
                rf_we   = 1'b1;
                flag_we = 1'b1;
            end
            4'h8: begin alu = DATA_W'(imm9); rf_we = 1'b1; end
            4'hA: if (br_take) pc_nxt = target;
            4'hF: begin halt_op = 1'b1; pc_nxt = pc; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (imem.imem_valid) state_nxt = EXEC;
            EXEC:    state_nxt = halt_op ? HALT : FETCH;
            HALT:    if (start) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= '0;
            ir           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            zero         <= 1'b0;
            negative     <= 1'b0;
            carry        <= 1'b0;
            overflow     <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            state        <= state_nxt;
            result_valid <= 1'b0;
            case (state)
                FETCH: if (imem.imem_valid) ir <= imem.imem_data;
                EXEC: begin
                    pc <= pc_nxt;
                    if (rf_we) begin
                        rf[rd]       <= alu;
                        result       <= alu;
                        result_valid <= 1'b1;
                    end
                    if (flag_we) begin
                        zero     <= (alu == '0);
                        negative <= alu[MSB];
                        carry    <= c_new;
                        overflow <= v_new;
                    end
                end
                HALT: if (start) pc <= '0;
                default: ;
            endcase
        end
    end

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign busy           = (state == FETCH) || (state == EXEC);
    assign halted         = (state == HALT);

endmodule
